// File: rtl/lockstep_wr_pkg.sv
// Shared types and widths for the lockstep register-file write checker.
package lockstep_wr_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    MISMATCH = 2'd1,
    OVERFLOW = 2'd2,
    TIMEOUT  = 2'd3
  } err_code_e;

endpackage

// File: rtl/lockstep_wr_fifo.sv
// Per-core write FIFO: push/pop/flush, combinational full/empty/head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module lockstep_wr_fifo
  import lockstep_wr_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  wr_entry_t push_data_i,
  input  logic      pop_i,
  output logic      full_c,
  output logic      empty_c,
  output wr_entry_t head_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wr_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full_c  = (count_q == CNT_W'(DEPTH));
    empty_c = (count_q == '0);
    head_c  = mem_q[rd_ptr_q];
    do_pop  = pop_i && !empty_c;
    do_push = push_i && (!full_c || do_pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/lockstep_wr_checker.sv
// Lockstep regfile write checker: buffers both cores' writes, compares them
// pairwise, commits agreed writes to a shadow regfile. Skew watchdog: LOCKSTEP_WR_TIMEOUT_EN.
module lockstep_wr_checker
  import lockstep_wr_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_a_i,
  input  logic [REG_ADDR_W-1:0] addr_a_i,
  input  logic [REG_DATA_W-1:0] data_a_i,
  input  logic                  we_b_i,
  input  logic [REG_ADDR_W-1:0] addr_b_i,
  input  logic [REG_DATA_W-1:0] data_b_i,
  input  logic                  clear_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic [REG_DATA_W-1:0] rd_data_o,
  output logic                  commit_o,
  output logic [REG_ADDR_W-1:0] commit_addr_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [REG_ADDR_W-1:0] err_addr_a_o,
  output logic [REG_ADDR_W-1:0] err_addr_b_o,
  output logic [REG_DATA_W-1:0] err_data_a_o,
  output logic [REG_DATA_W-1:0] err_data_b_o,
  output logic                  locked_o
);

  localparam int unsigned SKEW_W = $clog2(TIMEOUT + 1);

  wr_entry_t             entry_a, entry_b, head_a, head_b;
  logic                  push_a, push_b;
  logic                  full_a, full_b, empty_a, empty_b;
  logic                  can_cmp, heads_match, ovf, mism, tmo;
  logic                  err_fire, commit_fire;
  err_code_e             err_next;
  logic [REG_DATA_W-1:0] shadow_q [NUM_REGS];

  always_comb begin
    entry_a     = '{addr: addr_a_i, data: data_a_i};
    entry_b     = '{addr: addr_b_i, data: data_b_i};
    push_a      = we_a_i && (addr_a_i != '0);
    push_b      = we_b_i && (addr_b_i != '0);
    can_cmp     = !locked_o && !empty_a && !empty_b;
    heads_match = (head_a == head_b);
    ovf         = (push_a && full_a && !can_cmp) || (push_b && full_b && !can_cmp);
    mism        = can_cmp && !heads_match;
    commit_fire = can_cmp && heads_match;
    err_next    = lockstep_wr_pkg::NONE;
    if (ovf)       err_next = lockstep_wr_pkg::OVERFLOW;
    else if (mism) err_next = lockstep_wr_pkg::MISMATCH;
    else if (tmo)  err_next = lockstep_wr_pkg::TIMEOUT;
    err_fire    = !locked_o && (err_next != lockstep_wr_pkg::NONE);
  end

  lockstep_wr_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (clear_i),
    .push_i      (push_a),
    .push_data_i (entry_a),
    .pop_i       (can_cmp),
    .full_c      (full_a),
    .empty_c     (empty_a),
    .head_c      (head_a)
  );

  lockstep_wr_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (clear_i),
    .push_i      (push_b),
    .push_data_i (entry_b),
    .pop_i       (can_cmp),
    .full_c      (full_b),
    .empty_c     (empty_b),
    .head_c      (head_b)
  );

`ifdef LOCKSTEP_WR_TIMEOUT_EN
  logic [SKEW_W-1:0] skew_q;
  logic              skew_inc;

  // Count consecutive cycles where only one side has pending writes.
  assign skew_inc = !locked_o && (empty_a != empty_b);
  assign tmo      = skew_inc && (skew_q == SKEW_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || !skew_inc) skew_q <= '0;
    else                               skew_q <= skew_q + SKEW_W'(1);
  end
`else
  // Without the watchdog TIMEOUT only sizes an absent counter.
  logic unused_skew_cfg;
  assign tmo             = 1'b0;
  assign unused_skew_cfg = ^SKEW_W'(TIMEOUT);
`endif

  // Commit/error reporting, lock and shadow regfile; clear overrides everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      commit_o      <= 1'b0;
      commit_addr_o <= '0;
      err_o         <= 1'b0;
      err_code_o    <= '0;
      err_addr_a_o  <= '0;
      err_addr_b_o  <= '0;
      err_data_a_o  <= '0;
      err_data_b_o  <= '0;
      locked_o      <= 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) shadow_q[i] <= '0;
    end else begin
      commit_o <= 1'b0;
      err_o    <= 1'b0;
      if (clear_i) begin
        locked_o   <= 1'b0;
        err_code_o <= '0;
      end else begin
        if (commit_fire) begin
          commit_o               <= 1'b1;
          commit_addr_o          <= head_a.addr;
          shadow_q[head_a.addr]  <= head_a.data;
        end
        if (err_fire) begin
          err_o        <= 1'b1;
          err_code_o   <= 2'(err_next);
          locked_o     <= 1'b1;
          err_addr_a_o <= empty_a ? '0 : head_a.addr;
          err_data_a_o <= empty_a ? '0 : head_a.data;
          err_addr_b_o <= empty_b ? '0 : head_b.addr;
          err_data_b_o <= empty_b ? '0 : head_b.data;
        end
      end
    end
  end

  // x0 is never written, so its slot stays at its reset value of zero.
  always_comb begin
    rd_data_o = (rd_addr_i == '0) ? '0 : shadow_q[rd_addr_i];
  end

endmodule

// File: doc/lockstep_wr_checker.md
# lockstep_wr_checker

Upstream stage of the fault-tolerance module in the dual-core lockstep SoC. Takes the register-file write streams of both cores and buffers each in a small per-core FIFO, so that small skews between the cores are absorbed. It compares the writes pairwise in order and flags mismatch, overflow or excessive skew to the fault-tolerance module. Agreed writes are committed into a shadow (golden) register file, which the recovery sequencer reads when restoring the cores.

## Interface
Parameters:
- DEPTH, 4, entries per core FIFO (power of two, ≥2)
- TIMEOUT, 16, max consecutive cycles of one-sided skew before error (≥2)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- we_a_i / we_b_i  in  1  core 0 / core 1 regfile write enable
- addr_a_i / addr_b_i  in  5  regfile write address
- data_a_i / data_b_i  in  32  regfile write data
- clear_i  in  1  flush FIFOs, drop lock (issued by FT module after recovery)
- rd_addr_i  in  5  shadow regfile read address
- rd_data_o  out  32  shadow regfile read data, combinational
- commit_o  out  1  one-cycle pulse: one agreed write committed
- commit_addr_o  out  5  address of committed write
- err_o  out  1  one-cycle pulse on error detection
- err_code_o  out  2  error code, held until clear_i
- err_addr_a_o / err_addr_b_o  out  5  offending head addresses, held
- err_data_a_o / err_data_b_o  out  32  offending head data, held
- locked_o  out  1  sticky: error seen, comparison frozen

## Operation
- Push: core X pushes {addr,data} when we_X_i=1 and addr≠0. Writes to x0 are discarded.
- Compare: when locked_o=0 and both FIFOs are non-empty, pop both heads in the same cycle. If addresses and data are equal:
  - the shadow regfile is written;
  - commit_o=1 and commit_addr_o=addr are set.
- Mismatch: if the addresses or the data differ, raise error MISMATCH (code 1). The popped heads are latched into err_*_o.
- Overflow: a push to a FIFO that is full and not popping that cycle raises OVERFLOW (code 2) and the entry is lost. A push and a pop on a full FIFO in the same cycle is legal.
- Error priority in the same cycle: OVERFLOW > MISMATCH > TIMEOUT. Only the highest is reported.
- Lock:
  - On an error, locked_o=1 from the next cycle and err_code_o is held.
  - No further pops, commits or error reports while locked.
  - Pushes continue until the FIFOs fill; overflows while locked are silent.
- clear_i:
  - empties both FIFOs, clears locked_o and err_code_o, and zeroes the skew counter;
  - err_addr_*/err_data_* keep their last values;
  - the shadow regfile is preserved;
  - clear_i wins over any push, pop or error in the same cycle.
- Reset: FIFOs empty, shadow regfile zero, skew counter 0. Every output is 0: commit_o, commit_addr_o, err_o, err_code_o, err_addr_*, err_data_*, locked_o, and rd_data_o for all addresses.
- Shadow x0 always reads 0.

## Timing
- Equal-cycle writes at cycle N: entries are present at the end of N. The pop and compare happen in N+1. commit_o/err_o are registered and high in N+2. The shadow value is readable on rd_data_o in N+2.
- With skew k cycles (k<DEPTH, k<TIMEOUT), the compare happens one cycle after the later write.
- Throughput: one compare per cycle sustained.
- Counter widths: FIFO occupancy counter is clog2(DEPTH+1) bits; skew counter is clog2(TIMEOUT+1) bits.
- Pointers wrap modulo DEPTH.

## Configuration
- LOCKSTEP_WR_TIMEOUT_EN defined: skew watchdog is compiled in.
  - The skew counter increments each cycle that exactly one FIFO is non-empty and the checker is unlocked.
  - It resets to 0 otherwise.
  - When it reaches TIMEOUT, error TIMEOUT (code 3) is raised. err_*_o holds the non-empty head in the matching side and zeros on the other side.
- LOCKSTEP_WR_TIMEOUT_EN undefined: no counter; code 3 is never produced and skew is bounded only by overflow.

## Structure
- Package lockstep_wr_pkg holds:
  - wr_entry_t: packed {logic [4:0] addr; logic [31:0] data};
  - err_code_e: NONE=0, MISMATCH=1, OVERFLOW=2, TIMEOUT=3;
  - REG_ADDR_W=5, REG_DATA_W=32.
- Sub-module lockstep_wr_fifo: synchronous FIFO with DEPTH parameter, push/pop/flush, full/empty/head. It is instantiated once per core.
- The shadow regfile (31×32 flops) stays in the top level.

## Test plan
- Equal writes: both cores write x5=0xDEADBEEF at cycle 10 -> commit_o=1, commit_addr_o=5 at cycle 12; rd_addr_i=5 gives 0xDEADBEEF; err_o never asserted.
- Skew: core 0 writes x1=1,x2=2,x3=3 at cycles 10–12; core 1 writes the same at cycles 13–15 -> three commits at cycles 15, 16, 17, in order, with no error.
- Data mismatch: x7=0x10 vs x7=0x11 -> err_o pulse with err_code_o=1, err_data_a_o=0x10, err_data_b_o=0x11; locked_o=1. Subsequent matching writes do not commit. clear_i -> locked_o=0, and the next matching write commits.
- Overflow (DEPTH=4): core 0 writes 5 times while core 1 is idle -> err_code_o=2 on the fifth push. With the macro undefined, no code 3 is ever seen.
- Timeout (macro defined, TIMEOUT=16): core 0 writes x4 once and core 1 stays idle -> err_code_o=3 exactly 16 cycles after the entry is present, with err_addr_a_o=4.
- Edge cases: x0 writes from both cores produce no commit. clear_i coinciding with a mismatch pop -> no error and locked_o=0. rst_i mid-stream -> all outputs 0 the next cycle and shadow regfile reads 0.
